// File: rtl/load_use_stall_ctrl.sv
// Load-use hazard controller: tracks the single in-flight load (EX -> MEM) and
// stalls/bubbles younger ID instructions that need its result too early.
module load_use_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid_ip,
  input  logic [6:0]       id_opcode_ip,
  input  logic [4:0]       id_rs1_ip,
  input  logic [4:0]       id_rs2_ip,
  input  logic [4:0]       id_rd_ip,
  input  logic             mem_ack_ip,
  input  logic             flush_en_ip,
  output logic             stall_op,
  output logic             bubble_op,
  output logic [4:0]       pend_rd_op,
  output logic             mem_timeout_op,
  output logic [CNT_W-1:0] stall_cycles_op
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam int unsigned TW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LD_EX, LD_MEM} state_e;

  state_e           state_q, state_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic use_rs1, use_rs2;
  logic dep, is_load, blocked, stall, issue;
  logic [TW-1:0] wait_inc;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_opcode_ip)
      OPC_OP, OPC_STORE, OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // pend_rd_q is zero whenever no load is in flight, so x0 never matches.
  assign dep = id_valid_ip && (pend_rd_q != 5'd0) &&
               ((use_rs1 && (id_rs1_ip == pend_rd_q)) ||
                (use_rs2 && (id_rs2_ip == pend_rd_q)));

  assign is_load = id_valid_ip && (id_opcode_ip == OPC_LOAD);
  assign blocked = (state_q == LD_EX) || ((state_q == LD_MEM) && !mem_ack_ip);
  assign stall   = (dep || is_load) && blocked && !flush_en_ip && !reset;
  assign issue   = is_load && !stall && !flush_en_ip;
  assign wait_inc = wait_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d   = LD_EX;
          pend_rd_d = id_rd_ip;
        end
      end
      LD_EX: state_d = LD_MEM;
      LD_MEM: begin
        if (mem_ack_ip) begin
          if (issue) begin
            state_d   = LD_EX;
            pend_rd_d = id_rd_ip;
          end else begin
            state_d   = IDLE;
            pend_rd_d = '0;
          end
        end else begin
          // Counter parks at the limit; the FSM keeps waiting for the ack.
          wait_cnt_d = (wait_cnt_q == TMO_LIM) ? wait_cnt_q : wait_inc;
          if (wait_inc == TMO_LIM) timeout_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        pend_rd_d = '0;
      end
    endcase

    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_rd_q   <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_op        = stall;
  assign bubble_op       = (stall || flush_en_ip) && !reset;
  assign pend_rd_op      = pend_rd_q;
  assign mem_timeout_op  = timeout_q;
  assign stall_cycles_op = stall_cnt_q;

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Directed bench for load_use_stall_ctrl: a load-age model predicts every output
// each cycle; literal checks pin the model on the hand-computed scenarios.
module tb_load_use_stall_ctrl;

  localparam int CW  = 4;
  localparam int TMO = 15;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid_ip;
  logic [6:0]    id_opcode_ip;
  logic [4:0]    id_rs1_ip, id_rs2_ip, id_rd_ip;
  logic          mem_ack_ip, flush_en_ip;
  logic          stall_op, bubble_op, mem_timeout_op;
  logic [4:0]    pend_rd_op;
  logic [CW-1:0] stall_cycles_op;

  load_use_stall_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_valid_ip(id_valid_ip), .id_opcode_ip(id_opcode_ip),
    .id_rs1_ip(id_rs1_ip), .id_rs2_ip(id_rs2_ip), .id_rd_ip(id_rd_ip),
    .mem_ack_ip(mem_ack_ip), .flush_en_ip(flush_en_ip),
    .stall_op(stall_op), .bubble_op(bubble_op), .pend_rd_op(pend_rd_op),
    .mem_timeout_op(mem_timeout_op), .stall_cycles_op(stall_cycles_op)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: the in-flight load is described by its age since issue
  // (age 1 = in EX, age >= 2 = waiting in MEM) and its count of missed acks.
  bit       ld_live;
  int       ld_rd;
  int       ld_age;
  int       miss;
  bit       tmo;
  int       stalls;

  int exp_stall, exp_bubble, exp_pend, exp_tmo, exp_cnt;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", int'(stall_op), exp_stall);
      check("bubble", int'(bubble_op), exp_bubble);
      check("pend_rd", int'(pend_rd_op), exp_pend);
      check("timeout", int'(mem_timeout_op), exp_tmo);
      check("stall_cycles", int'(stall_cycles_op), exp_cnt);
    end
  end

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {OP, STORE, BRANCH, OPIMM, LOAD, JALR};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {OP, STORE, BRANCH};
  endfunction

  function automatic void model_clear();
    ld_live = 1'b0; ld_rd = 0; ld_age = 0; miss = 0; tmo = 1'b0; stalls = 0;
  endfunction

  // One pipeline cycle: drive ID/memory inputs, predict outputs, advance model.
  task automatic cyc(input bit v, input logic [6:0] op, input int r1, input int r2,
                     input int rd, input bit ack, input bit fl);
    bit in_ex, waiting, dep, st;
    id_valid_ip  = v;
    id_opcode_ip = op;
    id_rs1_ip    = 5'(r1);
    id_rs2_ip    = 5'(r2);
    id_rd_ip     = 5'(rd);
    mem_ack_ip   = ack;
    flush_en_ip  = fl;
    in_ex   = ld_live && (ld_age == 1);
    waiting = ld_live && (ld_age >= 2) && !ack;
    dep = v && ld_live && (ld_rd != 0) &&
          ((reads_rs1(op) && r1 == ld_rd) || (reads_rs2(op) && r2 == ld_rd));
    st = (dep || (v && op == LOAD)) && (in_ex || waiting) && !fl;
    exp_stall  = int'(st);
    exp_bubble = int'(st || fl);
    exp_pend   = ld_live ? ld_rd : 0;
    exp_tmo    = int'(tmo);
    exp_cnt    = stalls;
    chk_en = 1'b1;
    @(posedge clk);
    if (ld_live && ld_age >= 2) begin
      if (ack) begin
        ld_live = 1'b0;
        miss = 0;
      end else begin
        miss++;
        if (miss >= TMO) tmo = 1'b1;
      end
    end else if (ld_live) begin
      ld_age++;
    end
    if (v && op == LOAD && !st && !fl) begin
      ld_live = 1'b1; ld_rd = rd; ld_age = 1; miss = 0;
    end
    if (st && stalls < (1 << CW) - 1) stalls++;
    #1;
  endtask

  task automatic nop(input bit ack);
    cyc(1'b0, 7'd0, 0, 0, 0, ack, 1'b0);
  endtask

  // Async reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    chk_en = 1'b0;
    reset  = 1'b1;
    #2;
    check("rst_stall", int'(stall_op), 0);
    check("rst_bubble", int'(bubble_op), 0);
    check("rst_pend", int'(pend_rd_op), 0);
    check("rst_tmo", int'(mem_timeout_op), 0);
    check("rst_cnt", int'(stall_cycles_op), 0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    id_valid_ip = 1'b0; id_opcode_ip = '0; id_rs1_ip = '0; id_rs2_ip = '0;
    id_rd_ip = '0; mem_ack_ip = 1'b0; flush_en_ip = 1'b0;
    model_clear();
    #3;
    do_reset();

    // Dependent load-use, ack on first MEM cycle
    cyc(1, LOAD, 1, 0, 5, 0, 0);
    check("s1_pend_ex", int'(pend_rd_op), 5);
    cyc(1, OP, 5, 1, 6, 0, 0);
    cyc(1, OP, 5, 1, 6, 1, 0);
    nop(0);
    check("s1_pend_done", int'(pend_rd_op), 0);
    check("s1_cnt", int'(stall_cycles_op), 1);

    // Slow memory: ack four cycles into MEM
    do_reset();
    cyc(1, LOAD, 1, 0, 5, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, OP, 5, 1, 6, 0, 0);
    cyc(1, OP, 5, 1, 6, 1, 0);
    nop(0);
    check("s2_cnt", int'(stall_cycles_op), 5);

    // x0 destination and unused operand fields
    do_reset();
    cyc(1, LOAD, 1, 0, 0, 0, 0);
    cyc(1, OP, 0, 0, 8, 0, 0);
    nop(1);
    cyc(1, LOAD, 2, 0, 7, 0, 0);
    cyc(1, LUI, 7, 7, 7, 0, 0);
    cyc(1, OPIMM, 1, 7, 9, 1, 0);
    nop(0);
    check("s3_cnt", int'(stall_cycles_op), 0);

    // Back-to-back loads
    do_reset();
    cyc(1, LOAD, 1, 0, 3, 0, 0);
    cyc(1, LOAD, 1, 0, 4, 0, 0);
    cyc(1, LOAD, 1, 0, 4, 1, 0);
    check("s4_pend", int'(pend_rd_op), 4);
    nop(0);
    nop(1);
    check("s4_cnt", int'(stall_cycles_op), 1);
    check("s4_pend_done", int'(pend_rd_op), 0);

    // Flush beats stall; dependent OP on ack cycle proves MEM was reached
    do_reset();
    cyc(1, LOAD, 1, 0, 5, 0, 0);
    cyc(1, OP, 5, 2, 6, 0, 1);
    check("s5_pend", int'(pend_rd_op), 5);
    cyc(1, OP, 5, 2, 6, 1, 0);
    nop(0);
    check("s5_cnt", int'(stall_cycles_op), 0);

    // Timeout boundary, then async reset mid-MEM
    do_reset();
    cyc(1, LOAD, 1, 0, 9, 0, 0);
    nop(0);
    for (int i = 0; i < TMO - 1; i++) nop(0);
    check("s6_tmo_before", int'(mem_timeout_op), 0);
    nop(0);
    check("s6_tmo_set", int'(mem_timeout_op), 1);
    for (int i = 0; i < 3; i++) nop(0);
    check("s6_tmo_sticky", int'(mem_timeout_op), 1);
    chk_en = 1'b0;
    id_valid_ip = 1'b1; id_opcode_ip = OP; id_rs1_ip = 5'd9; flush_en_ip = 1'b1;
    do_reset();
    nop(0);
    nop(0);

    // Stall counter saturation with narrow counter
    do_reset();
    cyc(1, LOAD, 1, 0, 5, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, OP, 1, 5, 6, 0, 0);
    check("s7_cnt_sat", int'(stall_cycles_op), 15);
    cyc(1, OP, 1, 5, 6, 1, 0);
    nop(0);
    check("s7_cnt_hold", int'(stall_cycles_op), 15);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/load_use_stall_ctrl.md
Name: load_use_stall_ctrl

Overview:
- Producer-side hazard controller for the 5-stage RISC-V pipeline.
- Tracks the single in-flight load from ID→EX→MEM and raises stall/bubble when a younger ID instruction needs a load result that forwarding cannot yet supply.
- Sits beside the forwarding controller. It guarantees that whenever forwarding selects EX or WB results, those results are valid.
- Also applies a structural stall for back-to-back loads, counts stall cycles, and flags memory timeouts.

Parameters:
- MEM_TIMEOUT, 15: LD_MEM cycles without mem_ack_ip before mem_timeout_op sets.
- CNT_W, 16: width of stall_cycles_op.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high reset
- id_valid_ip  input  1  ID holds a valid instruction
- id_opcode_ip  input  7  ID opcode (CORE_PKG OPCODE_* encodings)
- id_rs1_ip  input  5  ID source register 1
- id_rs2_ip  input  5  ID source register 2
- id_rd_ip  input  5  ID destination register
- mem_ack_ip  input  1  data memory returns load data this cycle
- flush_en_ip  input  1  squash ID (branch/JAL redirect)
- stall_op  output  1  hold PC and IF/ID
- bubble_op  output  1  inject NOP into ID/EX
- pend_rd_op  output  5  destination of the in-flight load, 0 if none
- mem_timeout_op  output  1  sticky timeout flag
- stall_cycles_op  output  CNT_W  saturating count of stall_op cycles

Behaviour:
- Reset (async, active-high):
  - state=IDLE; pend_rd=0; wait_cnt=0; stall_cycles_op=0; mem_timeout_op=0.
  - stall_op=0 and bubble_op=0 while reset is held.
- Source use, decoded from id_opcode_ip:
  - OP, STORE, BRANCH use rs1 and rs2.
  - OPIMM, LOAD, JALR use rs1 only.
  - LUI, AUIPC, JAL use none.
  - Any other opcode uses none.
- dep = id_valid_ip & pend_rd≠0 & a used source equals pend_rd. x0 never creates a dependence.
- FSM states IDLE, LD_EX, LD_MEM:
  - IDLE→LD_EX on issue.
  - LD_EX→LD_MEM unconditionally after 1 cycle.
  - LD_MEM→IDLE on mem_ack_ip when there is no issue.
  - LD_MEM→LD_EX on mem_ack_ip together with issue. pend_rd takes the new id_rd_ip.
  - LD_MEM holds without mem_ack_ip.
- issue = id_valid_ip & opcode==LOAD & ~stall_op & ~flush_en_ip. On issue, pend_rd←id_rd_ip, which may be 0. pend_rd clears to 0 on entry to IDLE.
- Data stall (combinational):
  - dep & state==LD_EX; or
  - dep & state==LD_MEM & ~mem_ack_ip.
  - In the mem_ack_ip cycle the dependent instruction proceeds. The result is forwarded via WB next cycle.
- Structural stall: a LOAD in ID while state==LD_EX, or while state==LD_MEM & ~mem_ack_ip.
- stall_op = (data | structural) & ~flush_en_ip. Flush has priority: the ID instruction is killed, not held.
- bubble_op = stall_op | flush_en_ip.
- Flush never alters state or pend_rd, because a load older than the flushing branch is already past ID.
- Timeout:
  - wait_cnt counts cycles in LD_MEM and clears on leaving LD_MEM.
  - When wait_cnt reaches MEM_TIMEOUT, mem_timeout_op←1. It holds until reset.
  - The FSM keeps waiting.
- stall_cycles_op increments each cycle stall_op=1 and saturates at all-ones (no wrap).
- All outputs are glitch-free functions of registered state plus the current inputs. There is no extra latency.

Test Plan:
- Dependent load-use:
  - Stimulus: LOAD x5 issues; next cycle OP x6=x5+x1; mem_ack_ip arrives the cycle after entering LD_MEM.
  - Required: stall_op=bubble_op=1 for exactly 1 cycle (LD_EX), 0 on the ack cycle; pend_rd_op=5 then 0; stall_cycles_op=1.
- Slow memory:
  - Stimulus: as above, mem_ack_ip 4 cycles into LD_MEM.
  - Required: stall_op high for 1+4=5 cycles; stall_cycles_op=5.
- x0 and unused operands:
  - Stimulus: LOAD x0 followed by OP using x0; or LOAD x7 followed by LUI x7 / OPIMM with rs2=7.
  - Required: stall_op never asserts.
- Back-to-back loads:
  - Stimulus: LOAD x3 then LOAD x4.
  - Required: the second load stalls 1 cycle (LD_EX); issues on the LD_MEM ack cycle; FSM goes LD_MEM→LD_EX; pend_rd_op=4.
- Flush vs stall:
  - Stimulus: dependent OP in ID during LD_EX with flush_en_ip=1.
  - Required: stall_op=0, bubble_op=1; FSM still reaches LD_MEM.
- Timeout and reset:
  - Stimulus: hold mem_ack_ip=0 for 15 cycles in LD_MEM.
  - Required: mem_timeout_op rises on cycle 15 and stays high; asynchronous reset mid-LD_MEM returns state=IDLE and all outputs to 0 immediately.
